// File: rtl/fir_test_sequencer.sv
// Run controller for the FIR self-check path: streams ROM stimulus into
// the FIR, samples the verifier result per sample and reports done/pass.
module fir_test_sequencer #(
   parameter int NUM_SAMPLES = 16,
   parameter int FIR_LATENCY = 3,
   parameter int CNT_W       = 8
) (
   input  logic                    system1000,
   input  logic                    system1000_rst,
   input  logic                    start,
   input  logic                    abort,
   output logic [CNT_W-1:0]        stim_addr,
   input  logic signed [15:0]      stim_data,
   output logic signed [15:0]      fir_in,
   output logic                    fir_valid,
   input  logic signed [15:0]      fir_out,
   output logic signed [15:0]      verify_in,
   input  logic                    verify_ok,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [CNT_W-1:0]        err_count,
   output logic [CNT_W-1:0]        chk_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FEED  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0] SAT   = '1;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [FIR_LATENCY-1:0] vline;
   logic                   chk_strobe;
   logic                   launch;
   logic                   issue;
   logic                   last_issue;
   logic                   last_chk;
   logic                   stop;
   logic [CNT_W-1:0]       chk_nxt;
   logic [CNT_W-1:0]       err_nxt;

   assign verify_in  = fir_out;
   assign chk_strobe = vline[FIR_LATENCY-1];
   assign launch     = start && !abort && (state == IDLE || state == DONE);
   assign stop       = abort && busy;
   // stim_addr rests at 0 outside FEED, so a launch issues sample 0 at once
   assign issue      = launch || (state == FEED);
   assign last_issue = (stim_addr == LAST);
   assign last_chk   = chk_strobe && (chk_nxt == TOTAL);

   always_comb begin
      chk_nxt = chk_count;
      err_nxt = err_count;
      if (chk_strobe) begin
         chk_nxt = chk_count + 1'b1;
         if (!verify_ok && err_count != SAT)
            err_nxt = err_count + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (launch)
               state_nxt = last_issue ? DRAIN : FEED;
            else if (abort)
               state_nxt = IDLE;
         end
         FEED: begin
            if (abort)
               state_nxt = IDLE;
            else if (last_issue)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (abort)
               state_nxt = IDLE;
            else if (last_chk)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         state     <= IDLE;
         stim_addr <= '0;
         fir_in    <= '0;
         fir_valid <= 1'b0;
         vline     <= '0;
         err_count <= '0;
         chk_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == FEED) || (state_nxt == DRAIN);
         done  <= (state == DRAIN) && (state_nxt == DONE);
         if (stop) begin
            // abandoned samples must never reach the counters
            vline     <= '0;
            fir_valid <= 1'b0;
            stim_addr <= '0;
         end else begin
            vline     <= (vline << 1) | FIR_LATENCY'(fir_valid);
            fir_valid <= issue;
            if (issue) begin
               fir_in    <= stim_data;
               stim_addr <= last_issue ? '0 : stim_addr + 1'b1;
            end
            if (launch) begin
               chk_count <= '0;
               err_count <= '0;
            end else begin
               chk_count <= chk_nxt;
               err_count <= err_nxt;
            end
            if (launch || abort)
               pass <= 1'b0;
            else if (state == DRAIN && last_chk)
               pass <= (err_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_fir_test_sequencer.sv
// Randomized bench for fir_test_sequencer against a per-cycle run model.
module tb_fir_test_sequencer;

   localparam int N  = 16;
   localparam int L  = 3;
   localparam int W  = 8;
   localparam int N2 = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                start;
   logic                abort;
   logic [W-1:0]        stim_addr;
   logic signed [15:0]  stim_data;
   logic signed [15:0]  fir_in;
   logic                fir_valid;
   logic signed [15:0]  fir_out;
   logic signed [15:0]  verify_in;
   logic                verify_ok;
   logic                busy;
   logic                done;
   logic                pass;
   logic [W-1:0]        err_count;
   logic [W-1:0]        chk_count;
   logic signed [15:0]  rom [256];

   logic                start2;
   logic [W-1:0]        stim_addr2;
   logic signed [15:0]  stim_data2;
   logic signed [15:0]  fir_in2;
   logic                fir_valid2;
   logic signed [15:0]  verify_in2;
   logic                busy2;
   logic                done2;
   logic                pass2;
   logic [W-1:0]        err_count2;
   logic [W-1:0]        chk_count2;

   int n_chk = 0;
   int n_err = 0;

   assign stim_data  = rom[stim_addr];
   assign stim_data2 = {8'h5A, stim_addr2};

   fir_test_sequencer #(.NUM_SAMPLES(N), .FIR_LATENCY(L), .CNT_W(W)) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .start          (start),
      .abort          (abort),
      .stim_addr      (stim_addr),
      .stim_data      (stim_data),
      .fir_in         (fir_in),
      .fir_valid      (fir_valid),
      .fir_out        (fir_out),
      .verify_in      (verify_in),
      .verify_ok      (verify_ok),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .chk_count      (chk_count)
   );

   fir_test_sequencer #(.NUM_SAMPLES(N2), .FIR_LATENCY(L), .CNT_W(W)) dut2 (
      .system1000     (clk),
      .system1000_rst (rst),
      .start          (start2),
      .abort          (1'b0),
      .stim_addr      (stim_addr2),
      .stim_data      (stim_data2),
      .fir_in         (fir_in2),
      .fir_valid      (fir_valid2),
      .fir_out        (16'sd0),
      .verify_in      (verify_in2),
      .verify_ok      (1'b0),
      .busy           (busy2),
      .done           (done2),
      .pass           (pass2),
      .err_count      (err_count2),
      .chk_count      (chk_count2)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One run started at t=0; stop_t>=0 aborts (or resets) in cycle stop_t.
   task automatic run(input logic [N-1:0] bad, input int stop_t,
                      input bit by_rst, input bit noisy);
      int  te;
      int  nchk;
      int  nerr;
      bit  stopped;
      bit  e_valid;
      bit  e_busy;
      bit  e_done;
      for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
      for (int t = 0; t <= N + L + 1; t++) begin
         start   = (t == 0) || (noisy && t >= 3 && t <= 6);
         abort   = !by_rst && (t == stop_t);
         rst     = by_rst && (t == stop_t);
         fir_out = 16'($urandom);
         if (t >= L + 1 && t <= N + L)
            verify_ok = !bad[t-L-1];
         else
            verify_ok = 1'($urandom);
         @(negedge clk);
         check("verify_in", 32'(verify_in), 32'(fir_out));
         if (t > 0) begin
            stopped = (stop_t >= 0) && (t > stop_t);
            te      = stopped ? stop_t : t;
            nchk    = te - L - 1;
            if (nchk < 0) nchk = 0;
            if (nchk > N) nchk = N;
            nerr = 0;
            for (int i = 0; i < nchk; i++)
               if (bad[i]) nerr++;
            if (stopped && by_rst) begin
               nchk = 0;
               nerr = 0;
            end
            e_valid = !stopped && (t <= N);
            e_busy  = !stopped && (t <= N + L);
            e_done  = !stopped && (t == N + L + 1);
            check("fir_valid", 32'(fir_valid), 32'(e_valid));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("chk_count", 32'(chk_count), nchk);
            check("err_count", 32'(err_count), nerr);
            check("pass", 32'(pass), 32'(e_done && nerr == 0));
            if (e_valid)
               check("fir_in", 32'(fir_in), 32'(rom[t-1]));
            if (stopped && by_rst) begin
               check("rst_fir_in", 32'(fir_in), 0);
               check("rst_addr", 32'(stim_addr), 0);
            end
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      int k;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      start2    = 1'b0;
      verify_ok = 1'b1;
      fir_out   = '0;
      for (int i = 0; i < 256; i++) rom[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_valid", 32'(fir_valid), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_pass", 32'(pass), 0);
      check("reset_err", 32'(err_count), 0);
      check("reset_chk", 32'(chk_count), 0);
      check("reset_addr", 32'(stim_addr), 0);
      check("reset_fir_in", 32'(fir_in), 0);
      @(posedge clk);
      #1;

      run('0, -1, 1'b0, 1'b0);
      run('0, -1, 1'b0, 1'b0);
      run(16'h0208, -1, 1'b0, 1'b0);
      run(16'($urandom), -1, 1'b0, 1'b1);
      run(16'($urandom), 5, 1'b0, 1'b0);

      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("start_abort_busy", 32'(busy), 0);
      check("start_abort_valid", 32'(fir_valid), 0);
      @(posedge clk);
      #1;

      run('0, -1, 1'b0, 1'b0);
      run(16'($urandom), 18, 1'b1, 1'b0);
      run(16'($urandom), -1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      k = 1;
      while (k < 400) begin
         @(negedge clk);
         if (done2) break;
         @(posedge clk);
         #1;
         k++;
      end
      check("sat_latency", k, N2 + L + 1);
      check("sat_err", 32'(err_count2), 255);
      check("sat_chk", 32'(chk_count2), N2);
      check("sat_pass", 32'(pass2), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
